// File: rtl/decode_if.sv
// decode_if: signal bundle between fetch/controller (master) and the decode stage (slave).
interface decode_if;
   logic        DecodeEnable, FetchDone, branch_taken, DecodeDone, stack_err;
   logic [31:0] instruction, nextPC, imm_ext, PCj, PCbranch, PCstack;
   logic [4:0]  func, rs1, rd, rs2, sa;
   logic [1:0]  itype, PCsrc;
   modport master (
      output DecodeEnable, FetchDone, instruction, nextPC, branch_taken,
      input  DecodeDone, func, itype, rs1, rd, rs2, sa, imm_ext, PCsrc, PCj, PCbranch, PCstack, stack_err
   );
   modport slave (
      input  DecodeEnable, FetchDone, instruction, nextPC, branch_taken,
      output DecodeDone, func, itype, rs1, rd, rs2, sa, imm_ext, PCsrc, PCj, PCbranch, PCstack, stack_err
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: captures the fetched instruction, splits its fields, computes jump/branch
// targets and next-PC select, and owns the return-address stack.
module decode_stage #(
   parameter int DEPTH = 8,
   parameter int PTRW  = 3
) (
   input logic     clk,
   input logic     reset,
   decode_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0, HOLD = 1'b1;
   logic [0:0]      state_q, state_d;
   logic [31:1]     instr_q, instr_d;
   logic [31:0]     pcj_q, pcj_d, pcb_q, pcb_d, pcs_q, pcs_d;
   logic [1:0]      src_q, src_d;
   logic            done_q, done_d, err_q, err_d;
   logic [PTRW:0]   cnt_q, cnt_d;
   logic [31:0]     stk_q [DEPTH];
   logic [31:0]     stk_d [DEPTH];
   logic            go, is_j, jal, stop, empty, full;
   logic [PTRW-1:0] top;
   logic [31:0]     cur_pc, imm;
   always_comb begin
      go      = state_q == IDLE && bus.DecodeEnable && bus.FetchDone;
      is_j    = bus.instruction[2:1] == 2'b01;
      jal     = is_j && bus.instruction[31:27] == 5'd1;
      stop    = bus.instruction[0];
      empty   = cnt_q == '0;
      full    = cnt_q == (PTRW+1)'(DEPTH);
      top     = cnt_q[PTRW-1:0] - 1'b1;
      cur_pc  = bus.nextPC - 32'd1;
      imm     = {{18{bus.instruction[16]}}, bus.instruction[16:3]};
      state_d = go ? HOLD : (state_q == HOLD && !bus.DecodeEnable) ? IDLE : state_q;
      done_d  = go;
      instr_d = go ? bus.instruction[31:1] : instr_q;
      pcj_d   = go ? {cur_pc[31:24], bus.instruction[26:3]} : pcj_q;
      pcb_d   = go ? cur_pc + imm : pcb_q;
      src_d   = !go ? src_q : is_j ? 2'b10 : (stop && !empty) ? 2'b11 :
                (bus.instruction[2:1] == 2'b10 && bus.branch_taken) ? 2'b01 : 2'b00;
      pcs_d   = pcs_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      stk_d   = stk_q;
      // JAL with stop bit is pop-then-push: the top entry is simply replaced
      if (go && jal) begin
         if (stop && !empty) stk_d[top] = bus.nextPC;
         else if (!full) begin
            stk_d[cnt_q[PTRW-1:0]] = bus.nextPC;
            cnt_d = cnt_q + 1'b1;
         end
         err_d = err_q | (stop ? empty : full);
      end else if (go && stop && !is_j) begin
         if (!empty) begin
            pcs_d = stk_q[top];
            cnt_d = cnt_q - 1'b1;
         end
         err_d = err_q | empty;
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         instr_q <= '0;
         pcj_q   <= '0;
         pcb_q   <= '0;
         pcs_q   <= '0;
         src_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         stk_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pcj_q   <= pcj_d;
         pcb_q   <= pcb_d;
         pcs_q   <= pcs_d;
         src_q   <= src_d;
         done_q  <= done_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         stk_q   <= stk_d;
      end
   assign bus.DecodeDone = done_q;
   assign bus.func       = instr_q[31:27];
   assign bus.rs1        = instr_q[26:22];
   assign bus.rd         = instr_q[21:17];
   assign bus.rs2        = instr_q[16:12];
   assign bus.sa         = instr_q[11:7];
   assign bus.itype      = instr_q[2:1];
   assign bus.imm_ext    = {{18{instr_q[16]}}, instr_q[16:3]};
   assign bus.PCsrc      = src_q;
   assign bus.PCj        = pcj_q;
   assign bus.PCbranch   = pcb_q;
   assign bus.PCstack    = pcs_q;
   assign bus.stack_err  = err_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, corner sequences and random decodes checked against a queue-based return-stack model.
`define CHK(n, a, e) chk(n, 32'(a), 32'(e))
module tb_decode_stage;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  decode_if bus();
  decode_stage #(.DEPTH(8), .PTRW(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [31:0] stk[$];
  logic [31:0] m_instr, m_pcj, m_pcb, m_pcs;
  logic [1:0]  m_src;
  logic        m_err;
  localparam logic [31:0] ADDI = 32'h08420104, JAL = 32'h08000022, STOP = 32'h08440705;
  typedef struct {
    logic [31:0] instr, npc;
    logic        bt;
    logic [1:0]  src;
    logic [31:0] pcb, pcs;
    logic        err;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    stk.delete();
    m_instr = 0; m_pcj = 0; m_pcb = 0; m_pcs = 0; m_src = 2'd0; m_err = 1'b0;
  endtask
  task automatic model(input logic [31:0] i, input logic [31:0] npc, input logic bt);
    logic [31:0] cur = npc - 32'd1;
    logic isj = i[2:1] == 2'b01;
    logic jal = isj && i[31:27] == 5'd1;
    logic stop = i[0];
    m_instr = i;
    m_pcb = cur + 32'($signed(i[16:3]));
    m_pcj = {cur[31:24], i[26:3]};
    m_src = isj ? 2'd2 : (stop && stk.size() > 0) ? 2'd3 : (i[2:1] == 2'b10 && bt) ? 2'd1 : 2'd0;
    if (jal && stop && stk.size() > 0) stk[stk.size()-1] = npc;
    else if (jal) begin
      if (stk.size() < 8) stk.push_back(npc);
      else m_err = 1'b1;
      if (stop) m_err = 1'b1;
    end else if (stop && !isj) begin
      if (stk.size() > 0) m_pcs = stk.pop_back();
      else m_err = 1'b1;
    end
  endtask
  task automatic check_all();
    `CHK("func", bus.func, m_instr[31:27]);
    `CHK("itype", bus.itype, m_instr[2:1]);
    `CHK("rs1", bus.rs1, m_instr[26:22]);
    `CHK("rd", bus.rd, m_instr[21:17]);
    `CHK("rs2", bus.rs2, m_instr[16:12]);
    `CHK("sa", bus.sa, m_instr[11:7]);
    `CHK("imm_ext", bus.imm_ext, $signed(m_instr[16:3]));
    `CHK("PCsrc", bus.PCsrc, m_src);
    `CHK("PCj", bus.PCj, m_pcj);
    `CHK("PCbranch", bus.PCbranch, m_pcb);
    `CHK("PCstack", bus.PCstack, m_pcs);
    `CHK("stack_err", bus.stack_err, m_err);
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] npc, input logic bt);
    bus.DecodeEnable = 1'b1; bus.FetchDone = 1'b1;
    bus.instruction = i; bus.nextPC = npc; bus.branch_taken = bt;
  endtask
  task automatic decode(input logic [31:0] i, input logic [31:0] npc, input logic bt);
    @(negedge clk);
    drive(i, npc, bt);
    @(posedge clk); #1;
    `CHK("DecodeDone", bus.DecodeDone, 1);
    model(i, npc, bt);
    check_all();
    @(negedge clk);
    bus.DecodeEnable = 1'b0; bus.FetchDone = 1'b0;
    @(posedge clk); #1;
    `CHK("DecodeDone_idle", bus.DecodeDone, 0);
    `CHK("PCsrc_held", bus.PCsrc, m_src);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; #2; reset = 1'b1;
    model_reset();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int pulses;
    logic [31:0] r;
    tbl[0] = '{ADDI, 32'd2, 1'b0, 2'd0, 32'd33,  32'd0, 1'b0};
    tbl[1] = '{ADDI, 32'd2, 1'b1, 2'd1, 32'd33,  32'd0, 1'b0};
    tbl[2] = '{JAL,  32'd3, 1'b0, 2'd2, 32'd6,   32'd0, 1'b0};
    tbl[3] = '{STOP, 32'd5, 1'b0, 2'd3, 32'd228, 32'd3, 1'b0};
    tbl[4] = '{STOP, 32'd7, 1'b0, 2'd0, 32'd230, 32'd3, 1'b1};
    tbl[5] = '{JAL,  32'd9, 1'b0, 2'd2, 32'd12,  32'd3, 1'b1};
    bus.DecodeEnable = 1'b0; bus.FetchDone = 1'b0; bus.instruction = 0;
    bus.nextPC = 0; bus.branch_taken = 1'b0;
    model_reset();
    #12;
    check_all();
    `CHK("DecodeDone_reset", bus.DecodeDone, 0);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      decode(tbl[k].instr, tbl[k].npc, tbl[k].bt);
      `CHK("tbl_PCsrc", bus.PCsrc, tbl[k].src);
      `CHK("tbl_PCbranch", bus.PCbranch, tbl[k].pcb);
      `CHK("tbl_PCstack", bus.PCstack, tbl[k].pcs);
      `CHK("tbl_stack_err", bus.stack_err, tbl[k].err);
      n_chk++;
      if (bus.PCsrc !== tbl[k].src) begin
        n_fail++;
        $display("FAIL tbl_src_inline %0d: got %0d expected %0d", k, bus.PCsrc, tbl[k].src);
      end
      n_chk++;
      if (bus.stack_err !== tbl[k].err) begin
        n_fail++;
        $display("FAIL tbl_err_inline %0d: got %0b expected %0b", k, bus.stack_err, tbl[k].err);
      end
      if (k == 0) begin
        `CHK("addi_rd", bus.rd, 1);
        `CHK("addi_imm", bus.imm_ext, 32);
      end
      if (k == 2) `CHK("jal_PCj", bus.PCj, 4);
    end
    @(negedge clk);
    drive(ADDI, 32'd2, 1'b1);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0; #1;
    model_reset();
    check_all();
    `CHK("DecodeDone_async_reset", bus.DecodeDone, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(JAL, 32'd3, 1'b0);
    @(posedge clk); #1;
    `CHK("decode_after_reset", bus.DecodeDone, 1);
    model(JAL, 32'd3, 1'b0);
    check_all();
    @(negedge clk) begin bus.DecodeEnable = 1'b0; bus.FetchDone = 1'b0; end
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      decode(JAL, k, 1'b0);
      `CHK("fill_err", bus.stack_err, k == 9);
      n_chk++;
      if (bus.stack_err !== (k == 9)) begin
        n_fail++;
        $display("FAIL fill_err_inline %0d: got %0b", k, bus.stack_err);
      end
    end
    for (int k = 8; k >= 1; k--) begin
      decode(STOP, 32'd50, 1'b0);
      `CHK("drain_PCstack", bus.PCstack, k);
      `CHK("drain_PCsrc", bus.PCsrc, 3);
      n_chk++;
      if (bus.PCstack !== 32'(k)) begin
        n_fail++;
        $display("FAIL drain_inline %0d: got %0d", k, bus.PCstack);
      end
    end
    do_reset();
    @(negedge clk);
    drive(JAL, 32'd100, 1'b0);
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      pulses += int'(bus.DecodeDone);
    end
    `CHK("single_pulse", pulses, 1);
    model(JAL, 32'd100, 1'b0);
    check_all();
    @(negedge clk) bus.DecodeEnable = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) drive(JAL, 32'd200, 1'b0);
    @(posedge clk); #1;
    `CHK("second_decode", bus.DecodeDone, 1);
    model(JAL, 32'd200, 1'b0);
    check_all();
    @(negedge clk) begin bus.DecodeEnable = 1'b0; bus.FetchDone = 1'b0; end
    decode(STOP, 32'd7, 1'b0);
    `CHK("hs_pop1", bus.PCstack, 200);
    decode(STOP, 32'd7, 1'b0);
    `CHK("hs_pop2", bus.PCstack, 100);
    do_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      if ($urandom_range(3) == 0) r = {5'd1, r[26:3], 2'b01, r[0]};
      else if ($urandom_range(2) == 0) r[0] = 1'b1;
      decode(r, $urandom, 1'($urandom_range(1)));
      if (n % 100 == 99) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
